// File: rtl/wb_arbiter_if.sv
// Bundle of writeback-arbiter signals: pipeline and divider writeback sources,
// decode-stage scoreboard query, and the register-file write port.
interface wb_arbiter_if;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;

    logic              pipe_wr_v;
    logic [REG_W-1:0]  pipe_rd;
    logic [DATA_W-1:0] pipe_wr_data;

    logic              div_done;
    logic              div_ready;
    logic [REG_W-1:0]  div_rd;
    logic [DATA_W-1:0] div_data;

    logic [REG_W-1:0]  iss_rs1;
    logic [REG_W-1:0]  iss_rs2;
    logic [REG_W-1:0]  iss_rd;
    logic              iss_rs1_v;
    logic              iss_rs2_v;
    logic              iss_rd_v;
    logic              iss_div;
    logic              stall_sb;

    logic              pipe_hold;

    logic              rf_we;
    logic [REG_W-1:0]  rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    // Pipeline/decode/divider side
    modport master (
        output pipe_wr_v, pipe_rd, pipe_wr_data,
        output div_done, div_rd, div_data,
        output iss_rs1, iss_rs2, iss_rd, iss_rs1_v, iss_rs2_v, iss_rd_v, iss_div,
        input  div_ready, stall_sb, pipe_hold, rf_we, rf_waddr, rf_wdata
    );

    // Arbiter side
    modport slave (
        input  pipe_wr_v, pipe_rd, pipe_wr_data,
        input  div_done, div_rd, div_data,
        input  iss_rs1, iss_rs2, iss_rd, iss_rs1_v, iss_rs2_v, iss_rd_v, iss_div,
        output div_ready, stall_sb, pipe_hold, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: pipeline has priority, divider result waits in a
// one-entry buffer; pending-divide scoreboard stalls decode. WB_STARVE_GUARD_EN adds pipe_hold.
module wb_arbiter (
    input  logic         clk,
    input  logic         reset,
    wb_arbiter_if.slave  bus
);
    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREGS  = 32;

    logic              buf_valid_q, buf_valid_d;
    logic [REG_W-1:0]  buf_rd_q,    buf_rd_d;
    logic [DATA_W-1:0] buf_data_q,  buf_data_d;
    logic              rf_we_q,     rf_we_d;
    logic [REG_W-1:0]  rf_waddr_q,  rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q,  rf_wdata_d;
    logic [NREGS-1:0]  pending_q,   pending_d;

    logic capture;
    logic drain;
    logic stall_c;
    logic issue_set;

    assign capture   = bus.div_done & ~buf_valid_q;
    assign drain     = buf_valid_q & ~bus.pipe_wr_v;
    assign stall_c   = (bus.iss_rs1_v & pending_q[bus.iss_rs1])
                     | (bus.iss_rs2_v & pending_q[bus.iss_rs2])
                     | (bus.iss_rd_v  & pending_q[bus.iss_rd]);
    assign issue_set = bus.iss_div & bus.iss_rd_v & ~stall_c & (bus.iss_rd != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_valid_q <= 1'b0;
            buf_rd_q    <= '0;
            buf_data_q  <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            pending_q   <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_rd_q    <= buf_rd_d;
            buf_data_q  <= buf_data_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            pending_q   <= pending_d;
        end
    end

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_rd_d    = buf_rd_q;
        buf_data_d  = buf_data_q;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        pending_d   = pending_q;

        // Pipeline wins the write port; writes to x0 are dropped but still consume the slot
        if (bus.pipe_wr_v) begin
            rf_we_d    = (bus.pipe_rd != '0);
            rf_waddr_d = bus.pipe_rd;
            rf_wdata_d = bus.pipe_wr_data;
        end else if (buf_valid_q) begin
            rf_we_d    = (buf_rd_q != '0);
            rf_waddr_d = buf_rd_q;
            rf_wdata_d = buf_data_q;
        end

        if (drain) begin
            buf_valid_d          = 1'b0;
            pending_d[buf_rd_q]  = 1'b0;
        end
        if (capture) begin
            buf_valid_d = 1'b1;
            buf_rd_d    = bus.div_rd;
            buf_data_d  = bus.div_data;
        end

        // A new issue to the same register overrides a same-edge clear
        if (issue_set) begin
            pending_d[bus.iss_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

`ifdef WB_STARVE_GUARD_EN
    logic [1:0] starve_q, starve_d;
    logic       pipe_hold_q, pipe_hold_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q    <= 2'd0;
            pipe_hold_q <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            pipe_hold_q <= pipe_hold_d;
        end
    end

    // Count cycles the buffered result loses to the pipeline; saturate and request a bubble
    always_comb begin
        starve_d    = starve_q;
        pipe_hold_d = pipe_hold_q;
        if (drain) begin
            starve_d    = 2'd0;
            pipe_hold_d = 1'b0;
        end else if (buf_valid_q && bus.pipe_wr_v) begin
            if (starve_q != 2'd3) begin
                starve_d = starve_q + 2'd1;
            end
            if (starve_d == 2'd3) begin
                pipe_hold_d = 1'b1;
            end
        end
    end

    assign bus.pipe_hold = pipe_hold_q;
`else
    assign bus.pipe_hold = 1'b0;
`endif

    assign bus.div_ready = ~buf_valid_q;
    assign bus.stall_sb  = stall_c;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
endmodule
